stepper_axis_driver: RTL and testbench

//  Single-axis stepper back end: one instance per motor, six behind the panel controller.

---
 rtl/stepper_axis_driver.sv | 166 ++++++++++++++++
 tb/tb_stepper_axis_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_axis_driver.sv
// Single-axis stepper back end: homing against the Stop switch and absolute moves.
// Drives the PU/DR/MF driver pins and tracks the current step position.
module stepper_axis_driver #(
  parameter int POS_W          = 10,
  parameter int PULSE_HALF     = 50,
  parameter int DIR_SETUP      = 20,
  parameter bit HOME_DIR       = 1'b0,
  parameter int MAX_HOME_STEPS = 1023
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             home_req,
  input  logic             tgt_valid,
  input  logic [POS_W-1:0] tgt_pos,
  input  logic             Stop,
  output logic             busy,
  output logic             homed,
  output logic             done,
  output logic             fault,
  output logic [POS_W-1:0] cur_pos,
  output logic             PU,
  output logic             DR,
  output logic             MF
);

  localparam int CMAX = (PULSE_HALF > DIR_SETUP) ? PULSE_HALF : DIR_SETUP;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int HS_W = $clog2(MAX_HOME_STEPS + 1);

  typedef enum logic [2:0] {
    UNHOMED,
    IDLE,
    SETUP,
    PULSE_HI,
    PULSE_LO
  } state_t;

  state_t           state;
  logic             is_home;
  logic [POS_W-1:0] tgt;
  logic [CNT_W-1:0] cnt;
  logic [HS_W-1:0]  hsteps;
  logic [POS_W-1:0] next_pos;

  // Stepping away from the switch counts up, toward it counts down.
  always_comb begin
    next_pos = (DR != HOME_DIR) ? cur_pos + POS_W'(1)
                                : cur_pos - POS_W'(1);
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state   <= UNHOMED;
      is_home <= 1'b0;
      tgt     <= '0;
      cnt     <= '0;
      hsteps  <= '0;
      busy    <= 1'b0;
      homed   <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      cur_pos <= '0;
      PU      <= 1'b0;
      DR      <= 1'b0;
      MF      <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        UNHOMED, IDLE: begin
          if (home_req) begin
            fault   <= 1'b0;
            is_home <= 1'b1;
            DR      <= HOME_DIR;
            MF      <= 1'b0;
            busy    <= 1'b1;
            hsteps  <= '0;
            cnt     <= CNT_W'(DIR_SETUP - 1);
            state   <= SETUP;
          end else if (tgt_valid && state == IDLE && homed) begin
            if (tgt_pos == cur_pos) begin
              done <= 1'b1;
            end else begin
              is_home <= 1'b0;
              tgt     <= tgt_pos;
              DR      <= (tgt_pos > cur_pos) ? ~HOME_DIR : HOME_DIR;
              MF      <= 1'b0;
              busy    <= 1'b1;
              cnt     <= CNT_W'(DIR_SETUP - 1);
              state   <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (is_home && Stop) begin
            cur_pos <= '0;
            homed   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            PU    <= 1'b1;
            cnt   <= CNT_W'(PULSE_HALF - 1);
            state <= PULSE_HI;
          end
        end
        PULSE_HI: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            PU    <= 1'b0;
            cnt   <= CNT_W'(PULSE_HALF - 1);
            state <= PULSE_LO;
          end
        end
        PULSE_LO: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (is_home) begin
            if (Stop) begin
              cur_pos <= '0;
              homed   <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else if (hsteps == HS_W'(MAX_HOME_STEPS - 1)) begin
              cur_pos <= next_pos;
              fault   <= 1'b1;
              homed   <= 1'b0;
              MF      <= 1'b1;
              busy    <= 1'b0;
              state   <= UNHOMED;
            end else begin
              cur_pos <= next_pos;
              hsteps  <= hsteps + HS_W'(1);
              PU      <= 1'b1;
              cnt     <= CNT_W'(PULSE_HALF - 1);
              state   <= PULSE_HI;
            end
          end else if (DR == HOME_DIR && Stop) begin
            // Hitting the limit mid-move re-references the axis.
            cur_pos <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else if (next_pos == tgt) begin
            cur_pos <= next_pos;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            cur_pos <= next_pos;
            PU      <= 1'b1;
            cnt     <= CNT_W'(PULSE_HALF - 1);
            state   <= PULSE_HI;
          end
        end
        default: begin
          state <= UNHOMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Directed bench for stepper_axis_driver: table of moves plus hand-written
// sequences for homing, timeout, collisions, limit abort and async reset.
module tb_stepper_axis_driver;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       home_req = 1'b0;
  logic       tgt_valid = 1'b0;
  logic [9:0] tgt_pos = '0;
  logic       Stop = 1'b0;
  logic       busy, homed, done, fault, PU, DR, MF;
  logic [9:0] cur_pos;

  int cmp = 0;
  int fails = 0;
  int cyc = 0;
  int pu_rises = 0;
  int r1 = -1;
  int r2 = -1;
  int acc_cyc = 0;
  int done_cyc = -1;

  stepper_axis_driver #(
    .POS_W(10), .PULSE_HALF(2), .DIR_SETUP(3),
    .HOME_DIR(1'b0), .MAX_HOME_STEPS(8)
  ) dut (
    .sysclk(sysclk), .rst(rst), .home_req(home_req),
    .tgt_valid(tgt_valid), .tgt_pos(tgt_pos), .Stop(Stop),
    .busy(busy), .homed(homed), .done(done), .fault(fault),
    .cur_pos(cur_pos), .PU(PU), .DR(DR), .MF(MF)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc++;

  always @(posedge PU) begin
    pu_rises++;
    if (pu_rises == 1) r1 = cyc;
    if (pu_rises == 2) r2 = cyc;
  end

  typedef struct {
    int tgt;
    int chk_dr;
    int exp_dr;
    int exp_pulses;
    int exp_pos;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic req(input logic h, input logic t, input int p);
    pu_rises = 0;
    r1 = -1;
    r2 = -1;
    done_cyc = -1;
    home_req = h;
    tgt_valid = t;
    tgt_pos = 10'(p);
    tick();
    home_req = 1'b0;
    tgt_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic run(input int stop_at, output int dn,
                     output int drc, output int to);
    logic dr0;
    dr0 = DR;
    dn = 0;
    drc = 0;
    to = 1;
    for (int i = 0; i < 300; i++) begin
      if (stop_at > 0 && pu_rises >= stop_at) Stop = 1'b1;
      if (done) begin
        if (dn == 0) done_cyc = cyc;
        dn++;
      end
      if (busy && DR !== dr0) drc++;
      if (!busy) begin
        to = 0;
        break;
      end
      tick();
    end
    tick();
    if (done) dn++;
  endtask

  int dn, drc, to;

  initial begin
    vecs[0] = '{tgt: 3, chk_dr: 1, exp_dr: 1, exp_pulses: 3, exp_pos: 3};
    vecs[1] = '{tgt: 1, chk_dr: 1, exp_dr: 0, exp_pulses: 2, exp_pos: 1};
    vecs[2] = '{tgt: 1, chk_dr: 0, exp_dr: 0, exp_pulses: 0, exp_pos: 1};
    vecs[3] = '{tgt: 6, chk_dr: 1, exp_dr: 1, exp_pulses: 5, exp_pos: 6};
    vecs[4] = '{tgt: 2, chk_dr: 1, exp_dr: 0, exp_pulses: 4, exp_pos: 2};

    tick();
    tick();
    chk("rst_pu", PU, 0);
    chk("rst_mf", MF, 1);
    chk("rst_dr", DR, 0);
    chk("rst_busy", busy, 0);
    chk("rst_homed", homed, 0);
    chk("rst_fault", fault, 0);
    chk("rst_pos", cur_pos, 0);
    rst = 1'b0;
    tick();

    // tgt_valid before homing is dropped
    req(1'b0, 1'b1, 4);
    run(0, dn, drc, to);
    chk("unhomed_move_busy", busy, 0);
    chk("unhomed_move_done", dn, 0);

    // homing, Stop after 5th pulse
    req(1'b1, 1'b0, 0);
    chk("home_dr", DR, 0);
    chk("home_mf", MF, 0);
    run(5, dn, drc, to);
    Stop = 1'b0;
    chk("home_timeout", to, 0);
    chk("home_pulses", pu_rises, 5);
    chk("home_done", dn, 1);
    chk("home_homed", homed, 1);
    chk("home_pos", cur_pos, 0);
    chk("home_dr_stable", drc, 0);

    foreach (vecs[k]) begin
      req(1'b0, 1'b1, vecs[k].tgt);
      if (vecs[k].chk_dr != 0) chk($sformatf("v%0d_dr", k), DR, vecs[k].exp_dr);
      run(0, dn, drc, to);
      chk($sformatf("v%0d_timeout", k), to, 0);
      chk($sformatf("v%0d_pulses", k), pu_rises, vecs[k].exp_pulses);
      chk($sformatf("v%0d_pos", k), cur_pos, vecs[k].exp_pos);
      chk($sformatf("v%0d_done", k), dn, 1);
      chk($sformatf("v%0d_drchg", k), drc, 0);
      if (vecs[k].exp_pulses > 0)
        chk($sformatf("v%0d_first_rise", k), r1 - acc_cyc, 3);
      else
        chk($sformatf("v%0d_done_lat", k), done_cyc - acc_cyc, 0);
      if (vecs[k].exp_pulses > 1)
        chk($sformatf("v%0d_period", k), r2 - r1, 4);
    end

    // tgt_valid while busy is ignored
    req(1'b0, 1'b1, 7);
    tick();
    tick();
    tgt_valid = 1'b1;
    tgt_pos = 10'd0;
    tick();
    tgt_valid = 1'b0;
    run(0, dn, drc, to);
    chk("busy_drop_pos", cur_pos, 7);
    chk("busy_drop_pulses", pu_rises, 5);
    chk("busy_drop_done", dn, 1);

    // home_req wins over tgt_valid
    req(1'b1, 1'b1, 9);
    chk("coll_dr", DR, 0);
    chk("coll_busy", busy, 1);
    run(2, dn, drc, to);
    Stop = 1'b0;
    chk("coll_pulses", pu_rises, 2);
    chk("coll_pos", cur_pos, 0);
    chk("coll_homed", homed, 1);

    // limit hit while moving toward home aborts and re-references
    req(1'b0, 1'b1, 4);
    run(0, dn, drc, to);
    chk("pre_abort_pos", cur_pos, 4);
    req(1'b0, 1'b1, 1);
    run(1, dn, drc, to);
    Stop = 1'b0;
    chk("abort_pulses", pu_rises, 1);
    chk("abort_pos", cur_pos, 0);
    chk("abort_done", dn, 1);

    // Stop ignored when moving away from home
    Stop = 1'b1;
    req(1'b0, 1'b1, 2);
    run(0, dn, drc, to);
    Stop = 1'b0;
    chk("away_stop_pulses", pu_rises, 2);
    chk("away_stop_pos", cur_pos, 2);

    // homing timeout
    req(1'b1, 1'b0, 0);
    run(0, dn, drc, to);
    chk("tmo_timeout", to, 0);
    chk("tmo_pulses", pu_rises, 8);
    chk("tmo_fault", fault, 1);
    chk("tmo_homed", homed, 0);
    chk("tmo_mf", MF, 1);
    chk("tmo_done", dn, 0);
    chk("tmo_dr_stable", drc, 0);
    req(1'b0, 1'b1, 5);
    run(0, dn, drc, to);
    chk("tmo_move_busy", busy, 0);
    chk("tmo_move_pulses", pu_rises, 0);
    chk("tmo_move_done", dn, 0);

    // Stop already active: zero-pulse homing, done after SETUP
    Stop = 1'b1;
    req(1'b1, 1'b0, 0);
    chk("pre_fault_clear", fault, 0);
    run(0, dn, drc, to);
    Stop = 1'b0;
    chk("stop_home_pulses", pu_rises, 0);
    chk("stop_home_done", dn, 1);
    chk("stop_home_lat", done_cyc - acc_cyc, 3);
    chk("stop_home_homed", homed, 1);

    // async reset during a high phase
    req(1'b0, 1'b1, 3);
    for (int i = 0; i < 20 && !PU; i++) tick();
    chk("pre_rst_pu", PU, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pu", PU, 0);
    chk("arst_mf", MF, 1);
    chk("arst_homed", homed, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
